dot_matrix_engine: RTL and testbench
====================================

# dot_matrix_engine

Parametrised, double-buffered two-colour LED dot-matrix scan engine for the keypad/matrix game platform. It stores red (player sprite) and green (map) planes and scans them row-by-row onto the matrix row/red/green pins. It adds buffer swap at frame boundaries, hardware horizontal scrolling of the green plane, and per-frame red/green collision reporting. It sits between the game logic (sprite/map writers) and the matrix pins, and replaces the fixed 8x8 row generator and mixer.

## Interface
- ROWS, 8, matrix rows (≥2)
- COLS, 8, matrix columns (≥2)
- SCAN_DIV, 1024, clk cycles per row dwell (≥2)
- SCROLL_FRAMES, 16, frames per scroll step (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe for back buffer
- wr_plane  in  1  0 = red plane, 1 = green plane
- wr_row  in  clog2(ROWS)  target row; values ≥ROWS are ignored
- wr_data  in  COLS  row bitmap, bit c = column c
- swap_req  in  1  request front/back swap at next frame boundary
- scroll_mode  in  2  00 hold, 01 scroll left, 10 scroll right, 11 home
- row  out  ROWS  one-hot active-high row select
- red  out  COLS  red column drive for the selected row
- green  out  COLS  green column drive (scrolled) for the selected row
- frame_start  out  1  1-cycle pulse on each frame boundary
- swap_ack  out  1  1-cycle pulse when a swap takes effect
- coll  out  1  1-cycle pulse: previous frame had red/green overlap
- scroll_ofs  out  clog2(COLS)  current green scroll offset

## Operation
- Storage: 2 banks × 2 planes × ROWS × COLS flops. The front pointer selects the displayed bank; the other bank is back. Reset clears all banks. Front = bank 0.
- Writes: when wr_en=1, wr_data is written to back[wr_plane][wr_row] using the back pointer in effect before the clock edge. A write on the swap edge therefore lands in the bank that becomes front.
- Divider: div counts 0..SCAN_DIV-1 and wraps. tick = (div==SCAN_DIV-1).
- On tick, row_idx advances by 1 mod ROWS. Outputs register the new row:
  - row = 1<<row_idx
  - red = front_red[row_idx]
  - green[c] = front_green[row_idx][(c+scroll_ofs) mod COLS]
- Frame boundary = a tick where row_idx wraps ROWS-1→0. On that edge:
  - If a swap is pending, the front pointer toggles, swap_ack pulses, and pending clears.
  - frame counter advances. When it reaches SCROLL_FRAMES it wraps to 0 and the offset steps: mode 01 +1 mod COLS, mode 10 −1 mod COLS, mode 00 unchanged. Mode 11 sets offset 0 on every boundary regardless of the counter.
  - The row-0 outputs loaded on this edge use the post-swap bank and the post-step offset.
  - frame_start pulses.
  - coll pulses if the overlap accumulator was set, then the accumulator clears.
- Overlap accumulator: on every non-boundary tick, and on the boundary tick after the clear, it is set if (red_next & green_next) ≠ 0 for the row being loaded. A collision is therefore reported at the boundary ending the frame in which it was displayed.
- swap_req: the request is latched into pending. Multiple requests before a boundary merge into a single swap. A request on the boundary edge itself is deferred to the next boundary.

## Timing
- Reset (asynchronous, active-low): div=0, row_idx=ROWS-1, frame counter=0, scroll_ofs=0, pending=0, accumulator=0, all banks cleared. row=0, red=0, green=0, frame_start=0, swap_ack=0, coll=0.
- First tick occurs at the SCAN_DIV-th rising edge after reset deasserts. That tick is a frame boundary: row becomes 1, and frame_start pulses with no coll.
- Row dwell is exactly SCAN_DIV cycles. Frame period is ROWS×SCAN_DIV cycles.
- Write-to-display latency is at most one frame after the covering swap_ack.
- frame_start, swap_ack and coll coincide on the boundary cycle when each applies. All are high for exactly one cycle.
- Reset asserted mid-frame returns every register to its reset value immediately; any pending swap is lost.

## Test plan
Use ROWS=8, COLS=8, SCAN_DIV=4, SCROLL_FRAMES=2 for all scenarios.
- Reset release with no writes -> row=0x01 at edge 4, then 0x02 at edge 8, and so on. red=green=0. frame_start pulses every 32 cycles; coll and swap_ack never pulse.
- Write red row3=0x81 and green row5=0x0F, then pulse swap_req -> swap_ack pulses at the next boundary. When row=0x08, red=0x81; when row=0x20, green=0x0F. No coll.
- Scroll left, green row0=0x01, mode 01 -> green on row0 reads 0x01, then after 2 frames 0x80 (ofs=1), then 0x40 (ofs=2). After 16 frames ofs returns to 0. Mode 11 -> ofs=0 at the next boundary.
- Collision: red row2=0x10, green row2=0x10, swap -> no coll at the swap boundary; coll pulses at the following boundary and every boundary after. Clearing green row2 and swapping stops coll one frame later.
- Three swap_req pulses within one frame plus a wr_en on the boundary edge -> exactly one swap_ack. The boundary-edge write is visible in the very next frame.
- Assert reset while row=0x10 with a swap pending -> all outputs go to 0 asynchronously. After release, no swap_ack occurs and the buffers read as zero.

Source files
------------

// File: rtl/dot_matrix_engine.sv
// dot_matrix_engine
//   Double-buffered two-colour LED dot-matrix scanner. Holds red (sprite)
//   and green (map) planes in two banks. It scans the front bank one row
//   at a time, scrolls the green plane horizontally, swaps banks at frame
//   boundaries and reports red/green overlap once per frame.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   wr_en        write strobe into the back bank
//   wr_plane     0 = red plane, 1 = green plane
//   wr_row       target row; values >= ROWS are ignored
//   wr_data      row bitmap, bit c = column c
//   swap_req     request a front/back swap at the next frame boundary
//   scroll_mode  00 hold, 01 left, 10 right, 11 home
//   row          one-hot active-high row select
//   red          red column drive for the selected row
//   green        scrolled green column drive for the selected row
//   frame_start  1-cycle pulse on each frame boundary
//   swap_ack     1-cycle pulse when a swap takes effect
//   coll         1-cycle pulse: the previous frame had red/green overlap
//   scroll_ofs   current green scroll offset
module dot_matrix_engine #(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int SCAN_DIV      = 1024,
    parameter int SCROLL_FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      wr_plane,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic                      swap_req,
    input  logic [1:0]                scroll_mode,
    output logic [ROWS-1:0]           row,
    output logic [COLS-1:0]           red,
    output logic [COLS-1:0]           green,
    output logic                      frame_start,
    output logic                      swap_ack,
    output logic                      coll,
    output logic [$clog2(COLS)-1:0]   scroll_ofs
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] OFS_LAST = CW'(COLS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [RW:0]   ROWS_W   = (RW + 1)'(ROWS);
    localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS - 1){1'b0}}, 1'b1};

    // [bank][plane][row]; plane 0 = red, plane 1 = green
    logic [COLS-1:0] mem_q [2][2][ROWS];

    logic [DW-1:0]   div_q,     div_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [FW-1:0]   frm_q,     frm_d;
    logic [CW-1:0]   ofs_q,     ofs_d;
    logic            front_q,   front_d;
    logic            pend_q,    pend_d;
    logic            acc_q,     acc_d;
    logic [ROWS-1:0] row_q,     row_d;
    logic [COLS-1:0] red_q,     red_d;
    logic [COLS-1:0] green_q,   green_d;
    logic            fs_q,      fs_d;
    logic            ack_q,     ack_d;
    logic            coll_q,    coll_d;

    logic            tick;
    logic            row_wrap;
    logic            bnd;
    logic            wr_ok;
    logic [COLS-1:0] red_n;
    logic [COLS-1:0] grn_raw;
    logic [COLS-1:0] green_n;

    assign wr_ok = ({1'b0, wr_row} < ROWS_W);

    always_comb begin
        tick      = (div_q == DIV_LAST);
        row_wrap  = (row_idx_q == ROW_LAST);
        bnd       = tick && row_wrap;

        div_d     = tick ? '0 : div_q + 1'b1;
        row_idx_d = row_idx_q;
        front_d   = front_q;
        pend_d    = pend_q | swap_req;
        frm_d     = frm_q;
        ofs_d     = ofs_q;
        acc_d     = acc_q;
        row_d     = row_q;
        red_d     = red_q;
        green_d   = green_q;
        fs_d      = bnd;
        ack_d     = bnd & pend_q;
        coll_d    = bnd & acc_q;

        if (tick) begin
            row_idx_d = row_wrap ? '0 : row_idx_q + 1'b1;
        end

        if (bnd) begin
            if (pend_q) begin
                front_d = ~front_q;
            end
            // A request arriving on the boundary edge is held for the next one.
            pend_d = swap_req;

            if (frm_q == FRM_LAST) begin
                frm_d = '0;
                case (scroll_mode)
                    2'b01:   ofs_d = (ofs_q == OFS_LAST) ? '0 : ofs_q + 1'b1;
                    2'b10:   ofs_d = (ofs_q == '0) ? OFS_LAST : ofs_q - 1'b1;
                    default: ofs_d = ofs_q;
                endcase
            end else begin
                frm_d = frm_q + 1'b1;
            end

            if (scroll_mode == 2'b11) begin
                ofs_d = '0;
            end
        end

        // Row data is fetched with the post-swap bank and post-step offset so
        // the row-0 load on a boundary already reflects both.
        red_n   = mem_q[front_d][1'b0][row_idx_d];
        grn_raw = mem_q[front_d][1'b1][row_idx_d];
        // Rotate right by the offset: green[c] = raw[(c + ofs) mod COLS].
        green_n = (grn_raw >> ofs_d) | (grn_raw << (COLS - 32'(ofs_d)));

        if (tick) begin
            row_d   = ROW_ONE << row_idx_d;
            red_d   = red_n;
            green_d = green_n;
            // On a boundary the accumulator restarts with the new row-0 overlap.
            acc_d   = (bnd ? 1'b0 : acc_q) | (|(red_n & green_n));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q     <= '{default: '0};
            div_q     <= '0;
            row_idx_q <= ROW_LAST;
            frm_q     <= '0;
            ofs_q     <= '0;
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            acc_q     <= 1'b0;
            row_q     <= '0;
            red_q     <= '0;
            green_q   <= '0;
            fs_q      <= 1'b0;
            ack_q     <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            // Uses the pre-edge back pointer, so a write on the swap edge
            // lands in the bank that becomes front.
            if (wr_en && wr_ok) begin
                mem_q[~front_q][wr_plane][wr_row] <= wr_data;
            end
            div_q     <= div_d;
            row_idx_q <= row_idx_d;
            frm_q     <= frm_d;
            ofs_q     <= ofs_d;
            front_q   <= front_d;
            pend_q    <= pend_d;
            acc_q     <= acc_d;
            row_q     <= row_d;
            red_q     <= red_d;
            green_q   <= green_d;
            fs_q      <= fs_d;
            ack_q     <= ack_d;
            coll_q    <= coll_d;
        end
    end

    assign row         = row_q;
    assign red         = red_q;
    assign green       = green_q;
    assign frame_start = fs_q;
    assign swap_ack    = ack_q;
    assign coll        = coll_q;
    assign scroll_ofs  = ofs_q;

endmodule

// File: tb/tb_dot_matrix_engine.sv
// tb_dot_matrix_engine
//   Directed bench for dot_matrix_engine with ROWS=8, COLS=8, SCAN_DIV=4,
//   SCROLL_FRAMES=2. Frame period is 32 cycles.
module tb_dot_matrix_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       wr_plane;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic [1:0] scroll_mode;
    logic [7:0] row;
    logic [7:0] red;
    logic [7:0] green;
    logic       frame_start;
    logic       swap_ack;
    logic       coll;
    logic [2:0] scroll_ofs;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fs     = 0;
    int n_ack    = 0;
    int n_coll   = 0;
    int cyc;

    dot_matrix_engine #(
        .ROWS          (8),
        .COLS          (8),
        .SCAN_DIV      (4),
        .SCROLL_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_plane    (wr_plane),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .scroll_mode (scroll_mode),
        .row         (row),
        .red         (red),
        .green       (green),
        .frame_start (frame_start),
        .swap_ack    (swap_ack),
        .coll        (coll),
        .scroll_ofs  (scroll_ofs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_start) n_fs++;
        if (swap_ack)    n_ack++;
        if (coll)        n_coll++;
    endtask

    task automatic to_boundary(output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (frame_start) begin
                found  = 1'b1;
                cycles = i;
                break;
            end
        end
        check("boundary_reached", {31'd0, found}, 32'd1);
    endtask

    task automatic to_row(input int r);
        logic       found;
        logic [7:0] target;
        found  = 1'b0;
        target = 8'(1 << r);
        for (int i = 0; i < 40; i++) begin
            step();
            if (row == target) begin
                found = 1'b1;
                break;
            end
        end
        check("row_reached", {31'd0, found}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        step();
        step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wr(input logic plane, input logic [2:0] r, input logic [7:0] d);
        wr_en    = 1'b1;
        wr_plane = plane;
        wr_row   = r;
        wr_data  = d;
        step();
        wr_en    = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        wr_en       = 1'b0;
        wr_plane    = 1'b0;
        wr_row      = '0;
        wr_data     = '0;
        swap_req    = 1'b0;
        scroll_mode = 2'b00;

        // ---- reset state and basic scan ----
        step();
        step();
        check("rst_row",   {24'd0, row},   32'h0);
        check("rst_red",   {24'd0, red},   32'h0);
        check("rst_green", {24'd0, green}, 32'h0);
        check("rst_fs",    {31'd0, frame_start}, 32'd0);
        check("rst_ofs",   {29'd0, scroll_ofs},  32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(); step(); step();
        check("edge3_row", {24'd0, row}, 32'h00);
        step();
        check("edge4_row",  {24'd0, row}, 32'h01);
        check("edge4_fs",   {31'd0, frame_start}, 32'd1);
        check("edge4_coll", {31'd0, coll}, 32'd0);
        step();
        check("fs_width", {31'd0, frame_start}, 32'd0);
        step(); step(); step();
        check("edge8_row", {24'd0, row}, 32'h02);
        n_fs = 0; n_ack = 0; n_coll = 0;
        for (int i = 0; i < 64; i++) step();
        check("fs_count_64",  n_fs,   32'd2);
        check("idle_no_ack",  n_ack,  32'd0);
        check("idle_no_coll", n_coll, 32'd0);
        to_boundary(cyc);
        to_boundary(cyc);
        check("frame_period", cyc, 32'd32);

        // ---- write + swap ----
        wr(1'b0, 3'd3, 8'h81);
        wr(1'b1, 3'd5, 8'h0F);
        pulse_swap();
        n_ack = 0; n_coll = 0;
        to_boundary(cyc);
        check("swap_ack_pulse", {31'd0, swap_ack}, 32'd1);
        to_row(3);
        check("r3_red",   {24'd0, red},   32'h81);
        check("r3_green", {24'd0, green}, 32'h00);
        to_row(5);
        check("r5_green", {24'd0, green}, 32'h0F);
        check("r5_red",   {24'd0, red},   32'h00);
        to_boundary(cyc);
        check("swap_ack_once", n_ack,  32'd1);
        check("wr_no_coll",    n_coll, 32'd0);

        // ---- scrolling ----
        do_reset();
        scroll_mode = 2'b01;
        wr(1'b1, 3'd0, 8'h01);
        pulse_swap();
        to_boundary(cyc);
        check("scr_b1_ack",   {31'd0, swap_ack},   32'd1);
        check("scr_b1_ofs",   {29'd0, scroll_ofs}, 32'd0);
        check("scr_b1_green", {24'd0, green},      32'h01);
        to_boundary(cyc);
        check("scr_b2_ofs",   {29'd0, scroll_ofs}, 32'd1);
        check("scr_b2_green", {24'd0, green},      32'h80);
        to_boundary(cyc);
        check("scr_b3_green", {24'd0, green},      32'h80);
        to_boundary(cyc);
        check("scr_b4_ofs",   {29'd0, scroll_ofs}, 32'd2);
        check("scr_b4_green", {24'd0, green},      32'h40);
        for (int i = 0; i < 12; i++) to_boundary(cyc);
        check("scr_b16_ofs",   {29'd0, scroll_ofs}, 32'd0);
        check("scr_b16_green", {24'd0, green},      32'h01);
        scroll_mode = 2'b10;
        to_boundary(cyc);
        to_boundary(cyc);
        check("scr_right_ofs",   {29'd0, scroll_ofs}, 32'd7);
        check("scr_right_green", {24'd0, green},      32'h02);
        scroll_mode = 2'b11;
        to_boundary(cyc);
        check("scr_home_ofs",   {29'd0, scroll_ofs}, 32'd0);
        check("scr_home_green", {24'd0, green},      32'h01);
        scroll_mode = 2'b00;

        // ---- collision ----
        do_reset();
        wr(1'b0, 3'd2, 8'h10);
        wr(1'b1, 3'd2, 8'h10);
        pulse_swap();
        to_boundary(cyc);
        check("col_swap_ack", {31'd0, swap_ack}, 32'd1);
        check("col_swap_b",   {31'd0, coll},     32'd0);
        to_row(2);
        check("col_r2", {24'd0, red & green}, 32'h10);
        to_boundary(cyc);
        check("col_b2", {31'd0, coll}, 32'd1);
        step();
        check("col_width", {31'd0, coll}, 32'd0);
        to_boundary(cyc);
        check("col_b3", {31'd0, coll}, 32'd1);
        wr(1'b0, 3'd2, 8'h10);
        wr(1'b1, 3'd2, 8'h00);
        pulse_swap();
        to_boundary(cyc);
        check("col_b4_ack", {31'd0, swap_ack}, 32'd1);
        check("col_b4",     {31'd0, coll},     32'd1);
        to_boundary(cyc);
        check("col_b5_clear", {31'd0, coll}, 32'd0);

        // ---- merged swaps + boundary-edge write ----
        do_reset();
        to_boundary(cyc);
        wr(1'b0, 3'd1, 8'h55);
        n_ack = 0;
        pulse_swap();
        step();
        pulse_swap();
        step();
        pulse_swap();
        to_row(7);
        step(); step(); step();
        wr_en    = 1'b1;
        wr_plane = 1'b1;
        wr_row   = 3'd6;
        wr_data  = 8'h3C;
        step();
        wr_en    = 1'b0;
        check("mrg_b2_fs",  {31'd0, frame_start}, 32'd1);
        check("mrg_b2_ack", {31'd0, swap_ack},    32'd1);
        to_row(1);
        check("mrg_r1_red", {24'd0, red}, 32'h55);
        to_row(6);
        check("mrg_r6_green", {24'd0, green}, 32'h3C);
        to_boundary(cyc);
        check("mrg_one_ack", n_ack, 32'd1);

        // ---- asynchronous reset mid-frame with a swap pending ----
        wr(1'b0, 3'd4, 8'hFF);
        pulse_swap();
        to_row(4);
        check("ar_pre_row", {24'd0, row}, 32'h10);
        #2;
        reset = 1'b0;
        #1;
        check("ar_row",   {24'd0, row},   32'h0);
        check("ar_red",   {24'd0, red},   32'h0);
        check("ar_green", {24'd0, green}, 32'h0);
        check("ar_ofs",   {29'd0, scroll_ofs}, 32'd0);
        check("ar_pulses", {29'd0, frame_start, swap_ack, coll}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        n_ack = 0;
        to_boundary(cyc);
        check("ar_b1_no_ack", {31'd0, swap_ack}, 32'd0);
        to_row(4);
        check("ar_r4_red", {24'd0, red}, 32'h00);
        pulse_swap();
        to_boundary(cyc);
        to_row(1);
        check("ar_r1_red", {24'd0, red}, 32'h00);
        to_row(6);
        check("ar_r6_green", {24'd0, green}, 32'h00);
        check("ar_ack_count", n_ack, 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
